// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the multi-cycle CPU control path: FSM state codes,
// opcode/funct constants, ALUOp/PCSrc/RegDst encodings and the decoded
// instruction class bundle passed from the class decoder to the sequencer.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BLTZ = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_SLL = 3'b101
  } alu_op_t;

  localparam logic [1:0] PC_SEQ = 2'b00;  // PC+4
  localparam logic [1:0] PC_BR  = 2'b01;  // branch target
  localparam logic [1:0] PC_RS  = 2'b10;  // rs (jr)
  localparam logic [1:0] PC_JMP = 2'b11;  // jump target

  localparam logic [1:0] RD_RA = 2'b00;   // $31
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_NE  = 2'b01,
    BR_LTZ = 2'b10
  } br_kind_t;

  // One-hot instruction class; exactly one field is set for any op/funct.
  typedef struct packed {
    logic jump;
    logic jr;
    logic branch;
    logic load;
    logic store;
    logic ralu;
    logic ialu;
    logic halt;
    logic nop;
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic         link;      // jal: write return address to $31
    logic         funct_ok;  // R-type funct is a known ALU operation
    br_kind_t     br_kind;
    alu_op_t      alu_op;
    logic         ext_sel;   // 1 = sign-extend imm16
  } decode_t;

  function automatic logic branch_taken(input br_kind_t kind, input logic zero,
                                        input logic sign);
    case (kind)
      BR_EQ:   return zero;
      BR_NE:   return ~zero;
      BR_LTZ:  return sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Purpose: classifies op/funct into a one-hot instruction class plus ALU/branch details.
// Latency: purely combinational, zero cycles.
// Backpressure: none; inputs come straight from the held instruction register.
// Ports: op, funct (in, 6 each) -> dec (out, decode_t bundle).
module instr_class_decode
  import cpu_defs_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output decode_t    dec
);

  always_comb begin
    dec          = '0;
    dec.alu_op   = ALU_ADD;
    dec.br_kind  = BR_EQ;
    dec.ext_sel  = 1'b1;
    dec.funct_ok = 1'b1;
    case (op)
      OP_R: begin
        if (funct == FN_JR) begin
          dec.cls.jr = 1'b1;
        end else begin
          dec.cls.ralu = 1'b1;
          case (funct)
            FN_ADD:  dec.alu_op = ALU_ADD;
            FN_SUB:  dec.alu_op = ALU_SUB;
            FN_AND:  dec.alu_op = ALU_AND;
            FN_OR:   dec.alu_op = ALU_OR;
            FN_SLT:  dec.alu_op = ALU_SLT;
            FN_SLL:  dec.alu_op = ALU_SLL;
            // Unknown funct still walks the ALU path so the PC advances,
            // but the write-back is suppressed downstream.
            default: dec.funct_ok = 1'b0;
          endcase
        end
      end
      OP_BLTZ: begin
        dec.cls.branch = 1'b1;
        dec.br_kind    = BR_LTZ;
        dec.alu_op     = ALU_SLT;
      end
      OP_J:   dec.cls.jump = 1'b1;
      OP_JAL: begin
        dec.cls.jump = 1'b1;
        dec.link     = 1'b1;
      end
      OP_BEQ: begin
        dec.cls.branch = 1'b1;
        dec.br_kind    = BR_EQ;
        dec.alu_op     = ALU_SUB;
      end
      OP_BNE: begin
        dec.cls.branch = 1'b1;
        dec.br_kind    = BR_NE;
        dec.alu_op     = ALU_SUB;
      end
      OP_ADDI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = ALU_ADD;
      end
      OP_SLTI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = ALU_SLT;
      end
      OP_ORI: begin
        dec.cls.ialu = 1'b1;
        dec.alu_op   = ALU_OR;
        dec.ext_sel  = 1'b0;
      end
      OP_LW:   dec.cls.load  = 1'b1;
      OP_SW:   dec.cls.store = 1'b1;
      OP_HALT: dec.cls.halt  = 1'b1;
      default: dec.cls.nop   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: IF/ID/EXE/MEM/WB sequencer for the multi-cycle CPU; one PC load per instruction.
// Latency: 2..5 cycles per instruction (jump/NOP 2, branch 3, ALU/sw 4, lw 5); halt parks in ID.
// Backpressure: none; op/funct are held by the IR from ID until the next IF.
// Ports: CLK, Reset (async active-low), op, funct, zero, sign in; state plus all
//        datapath strobes/selects out, combinational from the registered state.
module multicycle_control_unit
  import cpu_defs_pkg::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       ExtSel,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc
);

  state_t  cur_state;
  state_t  nxt_state;
  decode_t dec;

  instr_class_decode u_decode (
    .op    (op),
    .funct (funct),
    .dec   (dec)
  );

  assign state = cur_state;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cur_state <= S_IF;
    else        cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    PCWre     = 1'b0;
    PCSrc     = PC_SEQ;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ExtSel    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    RegDst    = RD_RA;
    WrRegDSrc = 1'b1;
    RegWre    = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;

    // Operand/ALU selects are harmless outside EXE, so drive them whenever
    // the IR holds a valid instruction to keep the datapath settled early.
    if (cur_state != S_IF) begin
      ExtSel  = dec.ext_sel;
      ALUSrcB = dec.cls.ialu | dec.cls.load | dec.cls.store;
      ALUOp   = dec.alu_op;
    end

    case (cur_state)
      S_IF: begin
        IRWre     = 1'b1;
        InsMemRW  = 1'b1;
        nxt_state = S_ID;
      end
      S_ID: begin
        if (dec.cls.branch) begin
          nxt_state = S_EXE_BR;
        end else if (dec.cls.load | dec.cls.store) begin
          nxt_state = S_EXE_LS;
        end else if (dec.cls.ralu | dec.cls.ialu) begin
          nxt_state = S_EXE_AL;
        end else if (dec.cls.halt) begin
          nxt_state = S_ID;
        end else begin
          // j / jal / jr / unknown op: finish here with the PC load.
          PCWre     = 1'b1;
          nxt_state = S_IF;
          if (dec.cls.jump)    PCSrc = PC_JMP;
          else if (dec.cls.jr) PCSrc = PC_RS;
          if (dec.link) begin
            RegWre    = 1'b1;
            RegDst    = RD_RA;
            WrRegDSrc = 1'b0;
          end
        end
      end
      S_EXE_BR: begin
        PCWre     = 1'b1;
        nxt_state = S_IF;
        if (branch_taken(dec.br_kind, zero, sign)) PCSrc = PC_BR;
      end
      S_EXE_LS: nxt_state = S_MEM;
      S_MEM: begin
        if (dec.cls.load) begin
          mRD       = 1'b1;
          DBDataSrc = 1'b1;
          nxt_state = S_WB_LD;
        end else begin
          mWR       = dec.cls.store;
          PCWre     = 1'b1;
          nxt_state = S_IF;
        end
      end
      S_WB_LD: begin
        mRD       = 1'b1;
        DBDataSrc = 1'b1;
        RegWre    = 1'b1;
        RegDst    = RD_RT;
        PCWre     = 1'b1;
        nxt_state = S_IF;
      end
      S_EXE_AL: nxt_state = S_WB_AL;
      S_WB_AL: begin
        PCWre     = 1'b1;
        RegWre    = dec.cls.ialu | (dec.cls.ralu & dec.funct_ok);
        RegDst    = dec.cls.ralu ? RD_RD : RD_RT;
        nxt_state = S_IF;
      end
      default: nxt_state = S_IF;
    endcase
  end

endmodule
